matmul_result_streamer: RTL and testbench

Drains the accumulator matrix C produced by the matmul core and serializes it onto an AXI4-Stream master port toward the output DMA/interconnect.
- On the core's done pulse it snapshots C[M][N] into a local buffer, so the core may immediately start the next computation.
- It then emits M*N beats in row-major order with full tvalid/tready backpressure and tlast on the final element.

---
 rtl/matmul_result_streamer.sv | 185 ++++++++++++++++++
 tb/tb_matmul_result_streamer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_result_streamer.sv
// ----------------------------------------------------------------------------
// matmul_result_streamer
//
// Copies the matmul core's accumulator matrix C into a local buffer when the
// core pulses done. The core can then start its next computation while this
// block sends the buffered matrix over an AXI4-Stream master port.
// Elements go out in row-major order, one beat per cycle, with full
// tvalid/tready backpressure.
//
// Ports:
//   clk            clock, all logic on the rising edge
//   rst            asynchronous active-high reset
//   C              result matrix [M][N] of signed ACC_W-bit elements,
//                  valid in the cycle done=1
//   done           single-cycle pulse from the core: C is valid
//   clr_overrun    synchronous clear of the sticky overrun flag
//   m_axis_tdata   current element, two's complement, bit-exact
//   m_axis_tvalid  beat valid
//   m_axis_tready  downstream ready
//   m_axis_tlast   final element of the matrix (index M*N-1)
//   m_axis_tuser   first element of the matrix (index 0)
//   busy           a frame is held and not yet fully transferred
//   overrun        sticky: done arrived while busy and was dropped
//   frame_cnt      count of fully transferred frames, wraps modulo 2^CNT_W
// ----------------------------------------------------------------------------
module matmul_result_streamer #(
    parameter int ACC_W = 32,
    parameter int M     = 2,
    parameter int N     = 2,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [ACC_W-1:0] C [M][N],
    input  logic                    done,
    input  logic                    clr_overrun,
    output logic [ACC_W-1:0]        m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tuser,
    output logic                    busy,
    output logic                    overrun,
    output logic [CNT_W-1:0]        frame_cnt
);

    // Index widths, at least one bit so that M=1 or N=1 still elaborates.
    localparam int RW = (M > 1) ? $clog2(M) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [RW-1:0] ROW_LAST = RW'(M - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(N - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] buf_q [M][N];
    logic [RW-1:0]           row_q;
    logic [CW-1:0]           col_q;

    logic handshake;
    logic at_last;
    logic last_hs;
    logic capture;
    logic drop;

    // ------------------------------------------------------------------
    // Handshake and event decode
    // ------------------------------------------------------------------
    assign handshake = m_axis_tvalid && m_axis_tready;
    assign at_last   = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign last_hs   = handshake && at_last;

    // A new matrix is taken either from IDLE, or on the tlast handshake.
    // The second case gives back-to-back frames with no bubble.
    assign capture   = done && ((state_q == IDLE) || last_hs);

    // done during a frame, other than on its final handshake, is dropped.
    assign drop      = done && (state_q == STREAM) && !last_hs;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: flops use non-blocking assignments so every register samples
    // pre-edge values, whatever order the blocks are evaluated in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tuser  = 1'b0;
        m_axis_tlast  = 1'b0;
        busy          = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (done) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // tvalid comes only from the state flop, never from tready.
                m_axis_tvalid = 1'b1;
                busy          = 1'b1;
                m_axis_tdata  = buf_q[row_q][col_q];
                m_axis_tuser  = (row_q == '0) && (col_q == '0);
                m_axis_tlast  = at_last;
                if (last_hs && !done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Snapshot buffer
    // ------------------------------------------------------------------
    // NOTE: the buffer has no reset. Its contents are only seen through
    // tdata while in STREAM, and STREAM is only entered after a capture.
    // Leaving it unreset lets it map to plain storage.
    always_ff @(posedge clk) begin
        if (capture) begin
            buf_q <= C;
        end
    end

    // ------------------------------------------------------------------
    // Row/column indices
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else if (capture || last_hs) begin
            // A new frame starts at [0][0]. A finished frame also parks
            // there, so the row index never walks past M-1.
            row_q <= '0;
            col_q <= '0;
        end else if (handshake) begin
            if (col_q == COL_LAST) begin
                col_q <= '0;
                row_q <= row_q + RW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Status: frame counter and sticky overrun
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            overrun   <= 1'b0;
        end else begin
            if (last_hs) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
            // A set and a clear in the same cycle leave the flag set.
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_matmul_result_streamer.sv
// ----------------------------------------------------------------------------
// tb_matmul_result_streamer
//
// Directed bench for matmul_result_streamer. It uses two instances: the
// default 2x2 and a 1x3. Each time the stimulus starts a frame, it pushes the
// hand-computed beats (data, tuser, tlast) into a queue. A monitor per
// instance pops one entry on every tvalid&&tready handshake and compares it.
// Inputs are driven just after the rising edge; outputs are sampled on the
// falling edge or between edges.
//
// A cycle number k names the interval just before rising edge k. The done
// pulse is held in cycle 0.
// ----------------------------------------------------------------------------
module tb_matmul_result_streamer;

    typedef struct packed {
        logic [31:0] data;
        logic        user;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr_overrun = 1'b0;

    // 2x2 instance
    logic signed [31:0] c_a [2][2];
    logic               done_a  = 1'b0;
    logic               ready_a = 1'b1;
    logic [31:0]        tdata_a;
    logic               tvalid_a, tlast_a, tuser_a, busy_a, overrun_a;
    logic [15:0]        fcnt_a;

    // 1x3 instance
    logic signed [31:0] c_b [1][3];
    logic               done_b  = 1'b0;
    logic               ready_b = 1'b1;
    logic [31:0]        tdata_b;
    logic               tvalid_b, tlast_b, tuser_b, busy_b, overrun_b;
    logic [15:0]        fcnt_b;

    beat_t q_a[$];
    beat_t q_b[$];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    matmul_result_streamer #(.ACC_W(32), .M(2), .N(2), .CNT_W(16)) dut_a (
        .clk           (clk),
        .rst           (rst),
        .C             (c_a),
        .done          (done_a),
        .clr_overrun   (clr_overrun),
        .m_axis_tdata  (tdata_a),
        .m_axis_tvalid (tvalid_a),
        .m_axis_tready (ready_a),
        .m_axis_tlast  (tlast_a),
        .m_axis_tuser  (tuser_a),
        .busy          (busy_a),
        .overrun       (overrun_a),
        .frame_cnt     (fcnt_a)
    );

    matmul_result_streamer #(.ACC_W(32), .M(1), .N(3), .CNT_W(16)) dut_b (
        .clk           (clk),
        .rst           (rst),
        .C             (c_b),
        .done          (done_b),
        .clr_overrun   (clr_overrun),
        .m_axis_tdata  (tdata_b),
        .m_axis_tvalid (tvalid_b),
        .m_axis_tready (ready_b),
        .m_axis_tlast  (tlast_b),
        .m_axis_tuser  (tuser_b),
        .busy          (busy_b),
        .overrun       (overrun_b),
        .frame_cnt     (fcnt_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitors: one pop and compare per handshake.
    always @(negedge clk) begin
        if (!rst && tvalid_a && ready_a) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_beat", tdata_a, 32'hxxxx_xxxx);
            end else begin
                beat_t e;
                e = q_a.pop_front();
                check("a_tdata", tdata_a, e.data);
                check("a_tuser", {31'd0, tuser_a}, {31'd0, e.user});
                check("a_tlast", {31'd0, tlast_a}, {31'd0, e.last});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && tvalid_b && ready_b) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_beat", tdata_b, 32'hxxxx_xxxx);
            end else begin
                beat_t e;
                e = q_b.pop_front();
                check("b_tdata", tdata_b, e.data);
                check("b_tuser", {31'd0, tuser_b}, {31'd0, e.user});
                check("b_tlast", {31'd0, tlast_b}, {31'd0, e.last});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [31:0] v0, input logic [31:0] v1,
                          input logic [31:0] v2, input logic [31:0] v3);
        c_a[0][0] = v0; c_a[0][1] = v1;
        c_a[1][0] = v2; c_a[1][1] = v3;
    endtask

    // Expected row-major beats for a 2x2 frame.
    task automatic expect_a(input logic [31:0] v0, input logic [31:0] v1,
                            input logic [31:0] v2, input logic [31:0] v3);
        q_a.push_back('{v0, 1'b1, 1'b0});
        q_a.push_back('{v1, 1'b0, 1'b0});
        q_a.push_back('{v2, 1'b0, 1'b0});
        q_a.push_back('{v3, 1'b0, 1'b1});
    endtask

    // Holds done for cycle 0 and returns at the start of cycle 1.
    task automatic start_a(input logic [31:0] v0, input logic [31:0] v1,
                           input logic [31:0] v2, input logic [31:0] v3);
        load_a(v0, v1, v2, v3);
        expect_a(v0, v1, v2, v3);
        done_a = 1'b1;
        tick();
        done_a = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q_a.delete();
        q_b.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        load_a(0, 0, 0, 0);
        c_b[0][0] = 0; c_b[0][1] = 0; c_b[0][2] = 0;

        // ---- Reset state ----
        tick();
        check("rst_tvalid", {31'd0, tvalid_a}, 32'd0);
        check("rst_tdata", tdata_a, 32'd0);
        check("rst_tuser_tlast", {30'd0, tuser_a, tlast_a}, 32'd0);
        check("rst_busy_overrun", {30'd0, busy_a, overrun_a}, 32'd0);
        check("rst_frame_cnt", {16'd0, fcnt_a}, 32'd0);
        do_reset();

        // ---- 1: basic 2x2 frame, tready=1 ----
        start_a(1, 2, 3, 4);
        for (int cyc = 1; cyc <= 4; cyc++) begin
            check("t1_busy", {31'd0, busy_a}, 32'd1);
            check("t1_tvalid", {31'd0, tvalid_a}, 32'd1);
            tick();
        end
        check("t1_tvalid_c5", {31'd0, tvalid_a}, 32'd0);
        check("t1_busy_c5", {31'd0, busy_a}, 32'd0);
        check("t1_frame_cnt", {16'd0, fcnt_a}, 32'd1);

        // ---- 2: backpressure ----
        // tready is low in cycles 1-3 and 5. Beats are accepted in cycles
        // 4, 6, 7 and 8, so the tlast beat goes in cycle 8.
        do_reset();
        ready_a = 1'b0;
        start_a(1, 2, 3, 4);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            ready_a = !(cyc <= 3 || cyc == 5);
            if (cyc <= 3) begin
                check("t2_hold_tdata", tdata_a, 32'd1);
                check("t2_hold_tuser", {31'd0, tuser_a}, 32'd1);
            end
            if (cyc == 5) check("t2_hold_beat2", tdata_a, 32'd2);
            if (cyc == 8) check("t2_tlast_c8", {31'd0, tlast_a}, 32'd1);
            tick();
        end
        ready_a = 1'b1;
        check("t2_tvalid_c9", {31'd0, tvalid_a}, 32'd0);
        check("t2_frame_cnt", {16'd0, fcnt_a}, 32'd1);

        // ---- 3: overrun, set-wins, clear ----
        do_reset();
        start_a(1, 2, 3, 4);                 // now cycle 1
        tick();                              // cycle 2
        check("t3_no_overrun_c2", {31'd0, overrun_a}, 32'd0);
        load_a(9, 9, 9, 9);
        done_a = 1'b1;
        tick();                              // cycle 3
        done_a = 1'b0;
        check("t3_overrun_c3", {31'd0, overrun_a}, 32'd1);
        done_a = 1'b1;                       // second drop plus clear: set wins
        clr_overrun = 1'b1;
        tick();                              // cycle 4
        done_a = 1'b0;
        clr_overrun = 1'b0;
        check("t3_set_wins", {31'd0, overrun_a}, 32'd1);
        for (int cyc = 4; cyc < 10; cyc++) tick();
        check("t3_overrun_c10", {31'd0, overrun_a}, 32'd1);
        clr_overrun = 1'b1;
        tick();                              // cycle 11
        clr_overrun = 1'b0;
        check("t3_cleared_c11", {31'd0, overrun_a}, 32'd0);
        check("t3_frame_cnt", {16'd0, fcnt_a}, 32'd1);

        // ---- 4: back-to-back frames ----
        do_reset();
        start_a(1, 2, 3, 4);                 // cycle 1
        tick(); tick(); tick();              // cycle 4: tlast handshake
        load_a(5, 6, 7, 8);
        expect_a(5, 6, 7, 8);
        done_a = 1'b1;
        tick();                              // cycle 5
        done_a = 1'b0;
        check("t4_tvalid_c5", {31'd0, tvalid_a}, 32'd1);
        check("t4_tdata_c5", tdata_a, 32'd5);
        check("t4_tuser_c5", {31'd0, tuser_a}, 32'd1);
        check("t4_frame_cnt_c5", {16'd0, fcnt_a}, 32'd1);
        tick(); tick(); tick(); tick();      // cycle 9
        check("t4_tvalid_c9", {31'd0, tvalid_a}, 32'd0);
        check("t4_overrun", {31'd0, overrun_a}, 32'd0);
        check("t4_frame_cnt", {16'd0, fcnt_a}, 32'd2);

        // ---- 5: reset mid-frame ----
        do_reset();
        start_a(1, 2, 3, 4);                 // cycle 1
        tick(); tick();                      // cycle 3: two beats accepted
        #2;
        rst = 1'b1;
        q_a.delete();
        #1;
        check("t5_tvalid_async", {31'd0, tvalid_a}, 32'd0);
        check("t5_busy_async", {31'd0, busy_a}, 32'd0);
        check("t5_frame_cnt", {16'd0, fcnt_a}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        start_a(1, 2, 3, 4);
        check("t5_restart_tdata", tdata_a, 32'd1);
        check("t5_restart_tuser", {31'd0, tuser_a}, 32'd1);
        tick(); tick(); tick(); tick();
        check("t5_frame_cnt_after", {16'd0, fcnt_a}, 32'd1);

        // ---- 6: signed extremes on 2x2, and a 1x3 frame ----
        do_reset();
        c_b[0][0] = 32'sd10; c_b[0][1] = -32'sd20; c_b[0][2] = 32'sd30;
        q_b.push_back('{32'd10,        1'b1, 1'b0});
        q_b.push_back('{32'hFFFF_FFEC, 1'b0, 1'b0});
        q_b.push_back('{32'd30,        1'b0, 1'b1});
        done_b = 1'b1;
        start_a(32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFE);
        done_b = 1'b0;
        check("t6_b_tuser_tlast_c1", {30'd0, tuser_b, tlast_b}, 32'd2);
        tick(); tick();                      // cycle 3: third beat of b
        check("t6_b_tlast_c3", {31'd0, tlast_b}, 32'd1);
        tick(); tick();                      // cycle 5
        check("t6_a_tvalid_c5", {31'd0, tvalid_a}, 32'd0);
        check("t6_b_tvalid_c5", {31'd0, tvalid_b}, 32'd0);
        check("t6_b_frame_cnt", {16'd0, fcnt_b}, 32'd1);

        // Every expected beat must have been consumed.
        check("a_queue_drained", q_a.size(), 32'd0);
        check("b_queue_drained", q_b.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
